// File: rtl/idli_pkg.sv
// Shared types for the idli SQI memory responder: the nibble slice, the
// SQI command codes and the responder state encoding.
package idli_pkg;

    typedef logic [3:0] slice_t;

    typedef enum logic [7:0] {
        SQI_CMD_WRITE = 8'h02,
        SQI_CMD_READ  = 8'h03
    } sqi_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } sqi_state_t;

    localparam int unsigned SQI_CMD_NIBBLES  = 2;
    localparam int unsigned SQI_ADDR_NIBBLES = 4;
    localparam int unsigned SQI_DUMMY_STEPS  = 2;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Single-port byte RAM, 2^AW entries. Read data appears the cycle after an
// enabled read and then holds until the next enabled read, which the
// responder relies on to keep a prefetched byte stable between steps.
module idli_sqi_ram_m #(
    parameter int unsigned AW = 16
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];
    logic [7:0] r_q;

    // one access per cycle: write, or read into the holding output register
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/idli_sqi_resp_m.sv
// SQI memory responder: decodes a 2-nibble command and 4-nibble address,
// then streams read data out or write data in, one nibble per step.
// Optional build macro: IDLI_SQI_DUMMY_EN adds two dummy steps before
// read data.
//
// state  | meaning
// IDLE   | deselected; first selected cycle moves to CMD
// CMD    | collecting the two command nibbles
// ADDR   | collecting four address nibbles, MSB first
// DUMMY  | two ignored steps before read data
// RDATA  | driving read nibbles, high then low, addr auto-increments
// WDATA  | collecting write nibbles, byte stored on the low nibble
// IGNORE | unknown command, wait for deselect
module idli_sqi_resp_m
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 16
) (
    input  logic   i_mem_gck,
    input  logic   i_mem_rst,
    input  logic   i_mem_sck,
    input  logic   i_mem_cs,
    input  slice_t i_mem_sio,
    output slice_t o_mem_sio,
    output logic   o_mem_sio_en
);

    sqi_state_t              r_state;
    sqi_state_t              w_state_nxt;
    logic [1:0]              r_cnt;
    logic                    r_lo;
    logic                    r_is_rd;
    slice_t                  r_cmd_hi;
    slice_t                  r_wnib;
    slice_t                  r_low;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic [DEPTH_LOG2-1:0]   w_addr_asm;
    logic [DEPTH_LOG2-1:0]   w_addr_inc;
    logic                    w_step;
    logic [7:0]              w_cmd;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [DEPTH_LOG2-1:0]   w_ram_addr;
    logic [7:0]              w_ram_wdata;
    logic [7:0]              w_ram_q;

    assign w_step     = i_mem_sck & ~i_mem_cs;
    assign w_cmd      = {r_cmd_hi, i_mem_sio};
    assign w_addr_asm = DEPTH_LOG2'({r_addr, i_mem_sio});
    assign w_addr_inc = r_addr + DEPTH_LOG2'(1);

    idli_sqi_ram_m #(.AW(DEPTH_LOG2)) u_ram (
        .i_clk   (i_mem_gck),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    // state register
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and RAM access; the first read byte is fetched on the
    // last address step so it is ready the following cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = {r_wnib, i_mem_sio};
        if (i_mem_cs) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = CMD;
                CMD: begin
                    if (w_step && r_cnt == 2'd1) begin
                        if (w_cmd == SQI_CMD_READ || w_cmd == SQI_CMD_WRITE) begin
                            w_state_nxt = ADDR;
                        end else begin
                            w_state_nxt = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (w_step && r_cnt == 2'd3) begin
                        if (r_is_rd) begin
                            w_ram_en   = 1'b1;
                            w_ram_addr = w_addr_asm;
`ifdef IDLI_SQI_DUMMY_EN
                            w_state_nxt = DUMMY;
`else
                            w_state_nxt = RDATA;
`endif
                        end else begin
                            w_state_nxt = WDATA;
                        end
                    end
                end
                DUMMY: begin
                    if (w_step && r_cnt == 2'd1) begin
                        w_state_nxt = RDATA;
                    end
                end
                RDATA: begin
                    if (w_step && !r_lo) begin
                        w_ram_en   = 1'b1;
                        w_ram_addr = w_addr_inc;
                    end
                end
                WDATA: begin
                    if (w_step && r_lo) begin
                        w_ram_en = 1'b1;
                        w_ram_we = 1'b1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
        if (i_mem_rst) begin
            w_ram_en = 1'b0;
        end
    end

    // nibble counters, address and byte assembly, advanced on steps
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            r_cnt    <= 2'd0;
            r_lo     <= 1'b0;
            r_is_rd  <= 1'b0;
            r_cmd_hi <= '0;
            r_wnib   <= '0;
            r_low    <= '0;
            r_addr   <= '0;
        end else if (i_mem_cs) begin
            r_cnt <= 2'd0;
            r_lo  <= 1'b0;
        end else if (w_step) begin
            case (r_state)
                IDLE, CMD: begin
                    if (r_cnt == 2'd0) begin
                        r_cmd_hi <= i_mem_sio;
                        r_cnt    <= 2'd1;
                    end else begin
                        r_cnt   <= 2'd0;
                        r_is_rd <= (w_cmd == SQI_CMD_READ);
                    end
                end
                ADDR: begin
                    r_addr <= w_addr_asm;
                    r_cnt  <= r_cnt + 2'd1;
                end
                DUMMY: r_cnt <= (r_cnt == 2'd1) ? 2'd0 : r_cnt + 2'd1;
                RDATA: begin
                    if (!r_lo) begin
                        r_low  <= w_ram_q[3:0];
                        r_lo   <= 1'b1;
                        r_addr <= w_addr_inc;
                    end else begin
                        r_lo <= 1'b0;
                    end
                end
                WDATA: begin
                    if (!r_lo) begin
                        r_wnib <= i_mem_sio;
                        r_lo   <= 1'b1;
                    end else begin
                        r_lo   <= 1'b0;
                        r_addr <= w_addr_inc;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // the low nibble comes from a saved copy because the RAM output has
    // already moved on to the next byte by then
    always_comb begin
        o_mem_sio    = '0;
        o_mem_sio_en = 1'b0;
        if (r_state == RDATA) begin
            o_mem_sio_en = 1'b1;
            o_mem_sio    = r_lo ? r_low : w_ram_q[7:4];
        end
    end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Self-checking bench for idli_sqi_resp_m: directed scenarios plus random
// write/read-back traffic against a byte-addressed memory model.
module tb_idli_sqi_resp_m;
    import idli_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   sck;
    logic   cs;
    slice_t sio_i;
    slice_t sio_o;
    logic   sio_en;

    int n_vec = 0;
    int n_err = 0;

`ifdef IDLI_SQI_DUMMY_EN
    localparam int DUMMY_N = 2;
`else
    localparam int DUMMY_N = 0;
`endif

    logic [7:0] model [int];
    logic [7:0] wq [$];

    idli_sqi_resp_m #(.DEPTH_LOG2(16)) dut (
        .i_mem_gck    (clk),
        .i_mem_rst    (rst),
        .i_mem_sck    (sck),
        .i_mem_cs     (cs),
        .i_mem_sio    (sio_i),
        .o_mem_sio    (sio_o),
        .o_mem_sio_en (sio_en)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle; inputs applied after a falling edge, outputs then
    // sampled at the next falling edge
    task automatic cyc(input logic c, input logic s, input slice_t d);
        cs = c; sck = s; sio_i = d;
        @(negedge clk);
    endtask

    task automatic stp(input slice_t d);
        cyc(1'b0, 1'b1, d);
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic deselect();
        cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
        chk("desel_en", sio_en, 0);
        chk("desel_sio", sio_o, 0);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a);
        stp(cmd[7:4]); gap();
        stp(cmd[3:0]);
        for (int i = 3; i >= 0; i--) begin
            gap();
            stp(a[i*4 +: 4]);
        end
    endtask

    // write the bytes in wq starting at a; optionally a trailing lone nibble
    task automatic do_write(input logic [15:0] a, input bit partial);
        logic [15:0] p = a;
        send_hdr(8'h02, a);
        foreach (wq[k]) begin
            gap(); stp(wq[k][7:4]);
            gap(); stp(wq[k][3:0]);
            model[int'(p)] = wq[k];
            p = p + 16'd1;
        end
        if (partial) stp(4'($urandom));
        deselect();
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        logic [15:0] p = a;
        logic [3:0]  e;
        send_hdr(8'h03, a);
        for (int d = 0; d < DUMMY_N; d++) begin
            chk("dummy_en", sio_en, 0);
            stp(4'($urandom));
        end
        for (int k = 0; k < 2 * n; k++) begin
            if (!model.exists(int'(p))) begin
                chk("model_has_addr", 0, 1);
                break;
            end
            e = (k % 2 == 0) ? model[int'(p)][7:4] : model[int'(p)][3:0];
            chk("rd_en", sio_en, 1);
            chk("rd_nib", sio_o, e);
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'b0, 1'b0, 4'($urandom));
                chk("rd_hold", sio_o, e);
            end
            stp(4'($urandom));
            if (k % 2 == 1) p = p + 16'd1;
        end
        deselect();
    endtask

    initial begin
        logic [15:0] a;
        int n;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", sio_en, 0);
        chk("rst_sio", sio_o, 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, '0);

        // write then read back two bytes
        wq = '{8'hA5, 8'h3C};
        do_write(16'h0010, 1'b0);
        do_read(16'h0010, 2);

        // address wrap at the top of memory
        wq = '{8'h11, 8'h22};
        do_write(16'hFFFF, 1'b0);
        do_read(16'hFFFF, 1);
        do_read(16'h0000, 1);
        do_read(16'hFFFF, 2);

        // partial byte discarded at deselect
        wq = '{8'h5E};
        do_write(16'h0021, 1'b0);
        wq = '{8'h77};
        do_write(16'h0020, 1'b1);
        do_read(16'h0020, 2);

        // unknown command ignored
        stp(4'hF); stp(4'hF);
        for (int i = 0; i < 20; i++) begin
            stp(4'($urandom));
            chk("badcmd_en", sio_en, 0);
        end
        deselect();
        do_read(16'h0010, 2);
        do_read(16'h0020, 2);

        // reset in the middle of a read
        send_hdr(8'h03, 16'h0010);
        for (int d = 0; d < DUMMY_N; d++) stp(4'($urandom));
        chk("pre_rst_nib", sio_o, 4'hA);
        stp(4'($urandom));
        rst = 1'b1;
        cyc(1'b0, 1'b1, 4'($urandom));
        rst = 1'b0;
        chk("midrst_en", sio_en, 0);
        chk("midrst_sio", sio_o, 0);
        do_read(16'h0011, 1);

        // random traffic
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 6);
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4))
                                            : 16'($urandom);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            do_write(a, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                stp(4'($urandom)); stp(4'h0 + 4'($urandom_range(4, 15)));
                repeat (3) stp(4'($urandom));
                chk("rnd_badcmd_en", sio_en, 0);
                deselect();
            end
            n = $urandom_range(1, n);
            do_read(a, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/idli_sqi_resp_m.md
IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 16, meaning log2 of storage size in bytes (byte address width).
REQ-002 SHALL have port i_mem_gck  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_mem_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_mem_sck  input  1  serial clock strobe from core, synchronous to i_mem_gck; cycle with i_mem_sck=1 and i_mem_cs=0 is a "step".
REQ-005 SHALL have port i_mem_cs  input  1  chip select, active-low.
REQ-006 SHALL have port i_mem_sio  input  slice_t (4)  nibble driven by core.
REQ-007 SHALL have port o_mem_sio  output  slice_t (4)  nibble driven to core.
REQ-008 SHALL have port o_mem_sio_en  output  1  high when o_mem_sio carries valid read data.

Function
REQ-009 SHALL implement states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-010 SHALL move IDLE->CMD on first cycle with i_mem_cs=0; the same cycle, if a step, captures the first command nibble.
REQ-011 SHALL capture 2 command nibbles (high first) then 4 address nibbles (MSB first); address truncated to DEPTH_LOG2 bits.
REQ-012 SHALL decode command 8'h03 as READ, 8'h02 as WRITE; any other value -> IGNORE until cs deasserts, o_mem_sio_en=0.
REQ-013 SHALL, for READ, drive o_mem_sio = mem[addr][7:4], o_mem_sio_en=1 on the cycle after the step capturing the last address nibble (or last dummy nibble, see REQ-021).
REQ-014 SHALL, in RDATA, advance per step: high nibble -> low nibble -> next byte high nibble; output updates the cycle after the step; holds between steps.
REQ-015 SHALL, for WRITE, capture nibbles high-then-low; byte written to mem[addr] on the step capturing the low nibble; addr then increments.
REQ-016 SHALL increment addr modulo 2^DEPTH_LOG2 (0xFFFF -> 0x0000 at default).
REQ-017 SHALL, on any cycle with i_mem_cs=1, return to IDLE next cycle and drive o_mem_sio_en=0, o_mem_sio=0; cs=1 overrides a simultaneous i_mem_sck.
REQ-018 SHALL discard a partially received write byte at cs deassert; memory unchanged.
REQ-019 SHALL ignore i_mem_sio while o_mem_sio_en=1.

Reset
REQ-020 SHALL on i_mem_rst=1 set state IDLE, o_mem_sio=0, o_mem_sio_en=0, addr=0, nibble counters=0; storage contents not reset; reset mid-transaction aborts it with no write of a partial byte.

Configuration
REQ-021 SHALL, with IDLI_SQI_DUMMY_EN defined, insert DUMMY state of 2 steps between ADDR and RDATA for READ (inputs ignored, o_mem_sio_en=0); without it, ADDR goes straight to RDATA; WRITE unaffected either way.

Structure
REQ-022 SHALL place sqi_cmd_t (READ=8'h03, WRITE=8'h02) and sqi_state_t enums in idli_pkg; slice_t reused from idli_pkg.
REQ-023 SHALL instantiate sub-module idli_sqi_ram_m: 2^DEPTH_LOG2 x 8 synchronous RAM, one read/write port, read data next cycle; responder prefetches to meet REQ-013 timing.

Verification
REQ-024 SHALL cover write then read: WRITE 0x02, addr 0x0010, bytes 0xA5 0x3C; then READ addr 0x0010 -> nibbles A,5,3,C with o_mem_sio_en=1.
REQ-025 SHALL cover wrap: WRITE addr 0xFFFF bytes 0x11 0x22 -> READ 0xFFFF gives 0x11, READ 0x0000 gives 0x22.
REQ-026 SHALL cover abort: WRITE addr 0x0020 byte 0x77 then high nibble 0x9, cs=1 -> READ 0x0020 gives 0x77, 0x0021 holds prior value.
REQ-027 SHALL cover bad command 0xFF with 20 further steps -> o_mem_sio_en stays 0, memory unchanged.
REQ-028 SHALL cover i_mem_rst=1 mid-READ -> next cycle o_mem_sio_en=0, o_mem_sio=0, state IDLE; new READ succeeds.
REQ-029 SHALL run REQ-024 with and without IDLI_SQI_DUMMY_EN, checking first data nibble appears 2 steps later when defined.
